// File: rtl/core_pkg.sv
// Shared core definitions: halt-triggering opcodes, fetch FSM states and the
// {pc, instr} entry layout used by the fetch front end.
package core_pkg;

  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALTED
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic is_halt_opcode(input logic [6:0] opcode);
    return (opcode == OPC_MISC_MEM) || (opcode == OPC_SYSTEM);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous circular-buffer FIFO with flush; read data is combinational
// from the head entry and masked to zero while empty.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop frees the slot in the same cycle, so a full queue can still accept.
  assign do_push = push && (!full || do_pop);
  assign count   = count_q;
  assign rdata   = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the PC, fetches from a combinational ROM
// into a small queue for ID, handles redirect flushes and FENCE/SYSTEM halts.
module fetch_queue
  import core_pkg::*;
#(
  parameter int               XLEN     = 32,
  parameter int               DEPTH    = 4,
  parameter int               IMEM_AW  = 6,
  parameter logic [XLEN-1:0]  RESET_PC = '0,
  localparam int              CW       = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [XLEN-1:0]    imem_data,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [XLEN-1:0]    id_pc,
  output logic [XLEN-1:0]    id_instr,
  output logic [CW-1:0]      occupancy,
  output logic               halted
);

  fetch_state_e        state_q, state_d;
  logic [XLEN-1:0]     pc_q, pc_d;
  logic                push, pop, empty, full;
  logic [2*XLEN-1:0]   head;

  assign imem_addr = pc_q[IMEM_AW+1:2];
  assign id_valid  = !empty;
  assign id_pc     = head[2*XLEN-1:XLEN];
  assign id_instr  = head[XLEN-1:0];
  assign halted    = (state_q == HALTED);
  // A redirect discards the head, so it must not also count as consumed.
  assign pop       = id_valid && id_ready && !redirect_valid;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push    = 1'b0;
    if (redirect_valid) begin
      pc_d    = redirect_pc & ~XLEN'(3);
      state_d = RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (!full || pop) begin
            push = 1'b1;
            pc_d = pc_q + XLEN'(4);
            if (is_halt_opcode(imem_data[6:0])) begin
              state_d = DRAIN;
            end
          end
        end
        DRAIN: begin
          if (empty || (pop && occupancy == CW'(1))) begin
            state_d = HALTED;
          end
        end
        HALTED: begin
          state_d = HALTED;
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  sync_fifo #(
    .WIDTH(2 * XLEN),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .flush(redirect_valid),
    .push (push),
    .wdata({pc_q, imem_data}),
    .pop  (pop),
    .rdata(head),
    .count(occupancy),
    .empty(empty),
    .full (full)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: stimulus queues the expected {pc, instr}
// stream, a negedge monitor checks every ID handshake against it.
module tb_fetch_queue;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_ready = 1'b0;
  logic [5:0]  imem_addr;
  logic [31:0] imem_data;
  logic        id_valid;
  logic [31:0] id_pc, id_instr;
  logic [2:0]  occupancy;
  logic        halted;

  logic        rst2 = 1'b1;
  logic        id_ready2 = 1'b0;
  logic [5:0]  imem_addr2;
  logic [31:0] imem_data2;
  logic        id_valid2;
  logic [31:0] id_pc2, id_instr2;
  logic [2:0]  occupancy2;
  logic        halted2;

  logic [31:0]  rom [64];
  fetch_entry_t exp_q[$];
  int           tests_run = 0;
  int           tests_failed = 0;

  localparam logic [31:0] ECALL = 32'h0000_0073;

  always #5 clk = ~clk;

  assign imem_data  = rom[imem_addr];
  assign imem_data2 = rom[imem_addr2];

  fetch_queue #(.XLEN(32), .DEPTH(4), .IMEM_AW(6), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_instr(id_instr),
    .occupancy(occupancy), .halted(halted)
  );

  fetch_queue #(.XLEN(32), .DEPTH(4), .IMEM_AW(6), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst2), .imem_addr(imem_addr2), .imem_data(imem_data2),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .id_valid(id_valid2), .id_ready(id_ready2), .id_pc(id_pc2), .id_instr(id_instr2),
    .occupancy(occupancy2), .halted(halted2)
  );

  function automatic logic [31:0] addi(input int idx);
    logic [11:0] imm;
    imm = 12'(idx);
    return {imm, 5'd0, 3'b000, 5'd1, 7'b0010011};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic rdy, input logic rv, input logic [31:0] rpc);
    rst            = r;
    id_ready       = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expectRun(input logic [31:0] start_pc, input int n);
    for (int i = 0; i < n; i++) begin
      fetch_entry_t e;
      e.pc    = start_pc + 32'(4 * i);
      e.instr = addi(int'(e.pc[7:2]));
      exp_q.push_back(e);
    end
  endtask

  // Monitor: every accepted head entry must match the next scoreboard entry.
  always @(negedge clk) begin
    if (!rst && !redirect_valid && id_valid && id_ready) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL unexpected_pop: got pc 0x%08h, expected no entry", id_pc);
      end else begin
        fetch_entry_t e;
        e = exp_q.pop_front();
        checkOutput("sb_pc", id_pc, e.pc);
        checkOutput("sb_instr", id_instr, e.instr);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = addi(i);

    // Reset values and steady one-per-cycle streaming.
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    tick(); tick();
    checkOutput("rst_id_valid", 32'(id_valid), 32'h0);
    checkOutput("rst_occupancy", 32'(occupancy), 32'h0);
    checkOutput("rst_halted", 32'(halted), 32'h0);
    checkOutput("rst_id_pc", id_pc, 32'h0);
    checkOutput("rst_id_instr", id_instr, 32'h0);
    exp_q.delete();
    expectRun(32'h0, 16);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("first_imem_addr", 32'(imem_addr), 32'h0);
    checkOutput("first_id_valid", 32'(id_valid), 32'h0);
    tick();
    checkOutput("stream_id_valid", 32'(id_valid), 32'h1);
    for (int i = 0; i < 8; i++) begin
      checkOutput("stream_occ_le1", 32'(occupancy <= 3'd1), 32'h1);
      checkOutput("stream_halted", 32'(halted), 32'h0);
      tick();
    end

    // Backpressure saturates the queue and freezes the PC.
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    exp_q.delete();
    expectRun(32'h0, 20);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 10; i++) tick();
    checkOutput("full_occupancy", 32'(occupancy), 32'h4);
    checkOutput("full_imem_addr", 32'(imem_addr), 32'h4);
    checkOutput("full_head_pc", id_pc, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    tick(); tick();
    checkOutput("refill_occupancy", 32'(occupancy), 32'h4);

    // Redirect on a full queue with id_ready high: flush, no pop.
    exp_q.delete();
    expectRun(32'h40, 8);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h41);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("redir_occupancy", 32'(occupancy), 32'h0);
    checkOutput("redir_id_valid", 32'(id_valid), 32'h0);
    checkOutput("redir_imem_addr", 32'(imem_addr), 32'h10);
    tick();
    checkOutput("redir_id_valid2", 32'(id_valid), 32'h1);
    checkOutput("redir_id_pc", id_pc, 32'h40);
    checkOutput("redir_id_instr", id_instr, addi(16));
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) tick();

    // ECALL at 0x0C drains then halts; redirect restarts fetch.
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    rom[3] = ECALL;
    exp_q.delete();
    expectRun(32'h0, 3);
    exp_q.push_back('{pc: 32'hC, instr: ECALL});
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    tick(); tick(); tick(); tick();
    checkOutput("drain_id_pc", id_pc, 32'hC);
    checkOutput("drain_halted", 32'(halted), 32'h0);
    checkOutput("drain_occupancy", 32'(occupancy), 32'h1);
    tick();
    checkOutput("halt_halted", 32'(halted), 32'h1);
    checkOutput("halt_id_valid", 32'(id_valid), 32'h0);
    tick(); tick(); tick();
    checkOutput("halt_stays", 32'(halted), 32'h1);
    checkOutput("halt_occupancy", 32'(occupancy), 32'h0);
    checkOutput("halt_imem_addr", 32'(imem_addr), 32'h4);
    checkOutput("halt_all_delivered", 32'(exp_q.size()), 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h20);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("unhalt_halted", 32'(halted), 32'h0);
    checkOutput("unhalt_imem_addr", 32'(imem_addr), 32'h8);
    tick();
    checkOutput("unhalt_id_valid", 32'(id_valid), 32'h1);
    checkOutput("unhalt_id_pc", id_pc, 32'h20);

    // Reset while draining with three entries held.
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    rom[3] = addi(3);
    rom[2] = ECALL;
    exp_q.delete();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) tick();
    checkOutput("drain3_occupancy", 32'(occupancy), 32'h3);
    checkOutput("drain3_imem_addr", 32'(imem_addr), 32'h3);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("mid_rst_occupancy", 32'(occupancy), 32'h0);
    checkOutput("mid_rst_id_valid", 32'(id_valid), 32'h0);
    checkOutput("mid_rst_halted", 32'(halted), 32'h0);
    checkOutput("mid_rst_imem_addr", 32'(imem_addr), 32'h0);
    rom[2] = addi(2);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("post_rst_fetch", 32'(occupancy), 32'h1);

    // PC wraps from 0xFFFFFFFC to 0.
    rst2      = 1'b0;
    id_ready2 = 1'b1;
    checkOutput("wrap_first_addr", 32'(imem_addr2), 32'h3F);
    tick();
    checkOutput("wrap_id_pc0", id_pc2, 32'hFFFF_FFFC);
    checkOutput("wrap_id_instr0", id_instr2, addi(63));
    tick();
    checkOutput("wrap_id_pc1", id_pc2, 32'h0);
    checkOutput("wrap_id_instr1", id_instr2, addi(0));
    tick();
    checkOutput("wrap_id_pc2", id_pc2, 32'h4);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction-fetch front end that replaces the free-running PC/IF stage of the pipelined core. It owns the PC, reads the combinational instruction memory, and buffers fetched {PC, instruction} pairs in a DEPTH-entry queue feeding ID with a valid/ready handshake. It accepts redirects from the branch resolution stage by flushing the queue, and implements the halt mechanism for FENCE and SYSTEM opcodes.

## Interface
- XLEN, 32, PC/instruction width
- DEPTH, 4, queue entries; power of two, ≥2
- IMEM_AW, 6, instruction-memory word-address width
- RESET_PC, 0, PC value after reset
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- imem_addr  out  IMEM_AW  word address = pc[IMEM_AW+1:2]
- imem_data  in  XLEN  instruction at imem_addr, same cycle (combinational ROM)
- redirect_valid  in  1  branch/jump taken; flush and refetch
- redirect_pc  in  XLEN  target; bits [1:0] ignored (forced 0)
- id_valid  out  1  head entry valid
- id_ready  in  1  ID accepts head this cycle
- id_pc  out  XLEN  PC of head entry
- id_instr  out  XLEN  instruction of head entry
- occupancy  out  $clog2(DEPTH+1)  entries held
- halted  out  1  halt instruction fully drained; fetch stopped

## Operation
- Reset (synchronous, active-high, overrides everything): pc=RESET_PC, queue empty, occupancy=0, id_valid=0, id_pc/id_instr=0, halted=0, state RUN.
- States: RUN, DRAIN, HALTED.
- RUN: push {pc, imem_data} when queue not full or a pop occurs the same cycle; on push pc ← pc+4 (mod 2^XLEN). If pushed instruction opcode[6:0] is 7'b0001111 or 7'b1110011 → DRAIN; that instruction is enqueued, nothing after it.
- DRAIN: no fetch, pc held. When queue becomes empty (last pop) → HALTED.
- HALTED: no fetch, halted=1. Exit only via redirect or rst.
- Pop: id_valid && id_ready; head pointer advances. Pop on empty is ignored.
- Redirect (any state, highest priority below rst): queue flushed (occupancy=0), pc ← {redirect_pc[XLEN-1:2],2'b00}, state RUN, halted=0; no push and no pop take effect that cycle even if id_ready=1.
- Full and no pop: no push, pc held (stall). Full with pop: push and pop both occur, occupancy unchanged.
- Pointers wrap modulo DEPTH; occupancy counts 0..DEPTH inclusive.
- id_pc/id_instr read combinationally from head entry; undefined content masked to 0 when empty.

## Timing
- Fetch→ID latency 1 cycle: entry pushed at edge N visible on id_* after edge N.
- Redirect asserted in cycle N: imem_addr shows target in N+1; id_valid=1 with target instruction in N+2.
- Post-reset: imem_addr=RESET_PC>>2 in first cycle with rst low; id_valid=1 the following cycle.
- halted rises the cycle after the pop that empties the queue in DRAIN.
- Steady state with id_ready=1: one instruction per cycle, occupancy ≤1.
- rst mid-DRAIN or mid-flush: all state returns to reset values next edge, no residual entries.

## Structure
- Shared package core_pkg: OPC_MISC_MEM (7'b0001111), OPC_SYSTEM (7'b1110011), fetch state enum {RUN, DRAIN, HALTED}, fetch entry struct {pc, instr}.
- One sub-module: sync_fifo (parametrised WIDTH, DEPTH, synchronous flush input, count output); fetch_queue holds the PC, halt FSM and redirect priority.

## Test plan
- Reset, ROM of ADDIs, id_ready=1 → id_pc 0,4,8,… one per cycle from cycle 1; occupancy ≤1; halted=0.
- id_ready=0 for 10 cycles, DEPTH=4 → occupancy saturates at 4, imem_addr frozen at 4; release → entries PC 0,4,8,12 in order, then 16.
- Full queue, redirect_valid with redirect_pc=0x41 and id_ready=1 same cycle → no pop, occupancy 0 next cycle, imem_addr=0x10, id_pc=0x40 two cycles after redirect.
- ECALL at PC 0x0C, id_ready=1 → PCs 0,4,8,0xC delivered, no 0x10 fetched, halted=1 cycle after 0xC popped; redirect to 0x20 → halted=0, id_pc=0x20 two cycles later.
- rst asserted while in DRAIN with occupancy=3 → next cycle occupancy=0, id_valid=0, halted=0, imem_addr=RESET_PC>>2.
- PC wrap: RESET_PC=0xFFFFFFFC → second fetch at PC 0, id_pc sequence 0xFFFFFFFC, 0x0.
